// File: rtl/rotation_matrix_gen.sv
// Iterative CORDIC generator for the 2x2 rotation matrix [cos sin; -sin cos].
// One micro-rotation per cycle; the matrix is held until the consumer accepts it.

`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 16
`endif

module rotation_matrix_gen #(
    parameter int ITERS      = 16,
    parameter int GUARD_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`FLOAT_BITS-1:0] angle,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`FLOAT_BITS-1:0] a11,
    output logic [`FLOAT_BITS-1:0] a12,
    output logic [`FLOAT_BITS-1:0] a21,
    output logic [`FLOAT_BITS-1:0] a22
);

    localparam int W  = `FLOAT_BITS;
    localparam int F  = `FLOAT_DCM_BITS;
    localparam int W1 = W + 1;
    localparam int IW = W + GUARD_BITS;
    localparam int FG = F + GUARD_BITS;
    localparam int CW = $clog2(ITERS);

    localparam logic signed [W1-1:0] PI_Q      = W1'($rtoi(3.14159265358979 * (2.0 ** F) + 0.5));
    localparam logic signed [W1-1:0] TWO_PI_Q  = W1'($rtoi(6.28318530717959 * (2.0 ** F) + 0.5));
    localparam logic signed [W1-1:0] HALF_PI_Q = W1'($rtoi(1.57079632679490 * (2.0 ** F) + 0.5));
    localparam logic signed [IW-1:0] K_INIT    = IW'($rtoi(0.6072529350088813 * (2.0 ** FG) + 0.5));
    localparam logic signed [W-1:0]  ONE       = W'(1) << F;
    localparam logic signed [IW-1:0] ONE_E     = IW'(ONE);
    localparam logic signed [IW-1:0] HALF_LSB  = IW'(1) << (GUARD_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic signed [IW-1:0]   x, y, z;
    logic [CW-1:0]          iter;
    logic                   neg;

    logic [IW-1:0]          atan_rom [2**CW];

    // Arctangent table is fixed at elaboration; index i holds atan(2^-i) in z units.
    for (genvar g = 0; g < 2**CW; g++) begin : g_atan
        localparam logic [IW-1:0] ATAN_V = IW'($rtoi($atan(1.0 / (2.0 ** g)) * (2.0 ** FG) + 0.5));
        assign atan_rom[g] = ATAN_V;
    end

    logic signed [W1-1:0]   ang_ext, ang_red, ang_fold;
    logic                   fold_neg;

    // Wrap into [-PI, PI] once, then fold into the CORDIC convergence range.
    always_comb begin
        ang_ext  = {angle[W-1], angle};
        ang_red  = ang_ext;
        if (ang_ext > PI_Q)
            ang_red = ang_ext - TWO_PI_Q;
        else if (ang_ext < -PI_Q)
            ang_red = ang_ext + TWO_PI_Q;
        ang_fold = ang_red;
        fold_neg = 1'b0;
        if (ang_red > HALF_PI_Q) begin
            ang_fold = ang_red - PI_Q;
            fold_neg = 1'b1;
        end else if (ang_red < -HALF_PI_Q) begin
            ang_fold = ang_red + PI_Q;
            fold_neg = 1'b1;
        end
    end

    logic signed [IW-1:0]   x_sh, y_sh, x_nx, y_nx, z_nx;
    logic signed [IW-1:0]   c_full, s_full, c_rnd, s_rnd;
    logic signed [W-1:0]    c_sat, s_sat;
    logic                   d;

    function automatic logic signed [W-1:0] sat_one(input logic signed [IW-1:0] v);
        if (v > ONE_E)
            return ONE;
        else if (v < -ONE_E)
            return -ONE;
        else
            return v[W-1:0];
    endfunction

    always_comb begin
        d      = ~z[IW-1];
        x_sh   = x >>> iter;
        y_sh   = y >>> iter;
        x_nx   = d ? x - y_sh : x + y_sh;
        y_nx   = d ? y + x_sh : y - x_sh;
        z_nx   = d ? z - atan_rom[iter] : z + atan_rom[iter];
        c_full = neg ? -x_nx : x_nx;
        s_full = neg ? -y_nx : y_nx;
        c_rnd  = (c_full + HALF_LSB) >>> GUARD_BITS;
        s_rnd  = (s_full + HALF_LSB) >>> GUARD_BITS;
        c_sat  = sat_one(c_rnd);
        s_sat  = sat_one(s_rnd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a11       <= ONE;
            a12       <= '0;
            a21       <= '0;
            a22       <= ONE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            iter      <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= K_INIT;
                        y        <= '0;
                        z        <= IW'(ang_fold) <<< GUARD_BITS;
                        neg      <= fold_neg;
                        iter     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    // The matrix registers only move on the final micro-rotation.
                    if (iter == CW'(ITERS - 1)) begin
                        a11       <= c_sat;
                        a12       <= s_sat;
                        a21       <= -s_sat;
                        a22       <= c_sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotation_matrix_gen.sv
// Self-checking bench for rotation_matrix_gen: spec-point table, handshake corner
// sequences, and random angles compared against a real-arithmetic cos/sin model.

module tb_rotation_matrix_gen;

    localparam int ITERS     = 16;
    localparam int ONE       = 65536;
    localparam int PI_Q      = 205887;
    localparam int HALF_PI_Q = 102944;
    localparam int TOL       = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] angle;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a11, a12, a21, a22;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int ang;
        int c;
        int s;
    } vec_t;

    vec_t table_v[$];

    always #5 clk = ~clk;

    rotation_matrix_gen #(.ITERS(ITERS), .GUARD_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle     (angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a11       (a11),
        .a12       (a12),
        .a21       (a21),
        .a22       (a22)
    );

    function automatic int modelCos(input int ang);
        real r;
        r = real'(ang) / 65536.0;
        return $rtoi($floor($cos(r) * 65536.0 + 0.5));
    endfunction

    function automatic int modelSin(input int ang);
        real r;
        r = real'(ang) / 65536.0;
        return $rtoi($floor($sin(r) * 65536.0 + 0.5));
    endfunction

    task automatic checkVal(input string name, input int act, input int exp, input int tol);
        int diff;
        vectors++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic checkOutput(input string tag, input int ec, input int es, input int tol);
        checkVal({tag, ".a11"}, int'($signed(a11)), ec, tol);
        checkVal({tag, ".a12"}, int'($signed(a12)), es, tol);
        checkVal({tag, ".a21"}, int'($signed(a21)), -es, tol);
        checkVal({tag, ".a22"}, int'($signed(a22)), ec, tol);
        checkVal({tag, ".a21_eq_neg_a12"}, int'($signed(a21)) + int'($signed(a12)), 0, 0);
        checkVal({tag, ".a22_eq_a11"}, int'($signed(a22)) - int'($signed(a11)), 0, 0);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic issueRequest(input int ang);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkVal("accept_ready", int'(in_ready === 1'b1), 1, 0);
        angle    = ang;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        angle    = $urandom;
    endtask

    task automatic waitOutput(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < ITERS + 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input int ang, output int lat);
        issueRequest(ang);
        waitOutput(lat);
    endtask

    task automatic releaseOutput();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int rises;
        int first_cyc;
        int second_cyc;
        int cyc;
        int ang;
        string tag;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        angle     = '0;

        table_v.push_back('{0,        ONE,    0});
        table_v.push_back('{HALF_PI_Q, 0,     ONE});
        table_v.push_back('{PI_Q,     -ONE,   0});
        table_v.push_back('{-HALF_PI_Q, 0,    -ONE});
        table_v.push_back('{51472,    46341,  46341});
        table_v.push_back('{308831,   0,      -ONE});
        table_v.push_back('{-PI_Q,    -ONE,   0});
        table_v.push_back('{68629,    32768,  56756});
        table_v.push_back('{-257359,  -46341, 46341});
        table_v.push_back('{514718,   0,      ONE});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkVal("reset.out_valid", int'(out_valid), 0, 0);
        checkVal("reset.in_ready", int'(in_ready), 1, 0);
        checkOutput("reset", ONE, 0, 0);

        for (int i = 0; i < table_v.size(); i++) begin
            tag = $sformatf("table[%0d]", i);
            applyStimulus(table_v[i].ang, lat);
            checkVal({tag, ".latency"}, lat, ITERS + 1, 0);
            checkOutput(tag, table_v[i].c, table_v[i].s, TOL);
            releaseOutput();
        end

        // Stalled consumer: matrix and handshake must hold; stray requests are ignored.
        applyStimulus(51472, lat);
        checkVal("stall.latency", lat, ITERS + 1, 0);
        for (int k = 0; k < 20; k++) begin
            checkVal("stall.out_valid", int'(out_valid), 1, 0);
            checkVal("stall.in_ready", int'(in_ready), 0, 0);
            checkOutput("stall", 46341, 46341, TOL);
            if (k == 10) begin
                angle    = PI_Q;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkVal("post_stall.out_valid", int'(out_valid), 0, 0);
        checkVal("post_stall.in_ready", int'(in_ready), 1, 0);
        angle    = -HALF_PI_Q;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkVal("post_stall.accepted", int'(in_ready), 0, 0);
        checkOutput("post_stall.held", 46341, 46341, TOL);
        waitOutput(lat);
        checkVal("post_stall.latency", lat, ITERS + 1, 0);
        checkOutput("post_stall", 0, -ONE, TOL);
        releaseOutput();

        // Back-to-back throughput with both sides always ready.
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        angle      = 34315;
        first_cyc  = -1;
        second_cyc = -1;
        cyc        = 0;
        while (second_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    checkOutput("b2b", 56756, 32768, TOL);
                end else begin
                    second_cyc = cyc;
                    in_valid   = 1'b0;
                end
            end
        end
        checkVal("b2b.period", second_cyc - first_cyc, ITERS + 2, 0);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        // Reset during RUN cycle 5 aborts back to the identity matrix.
        issueRequest(68629);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkVal("midrst.out_valid", int'(out_valid), 0, 0);
        checkVal("midrst.in_ready", int'(in_ready), 1, 0);
        checkOutput("midrst", ONE, 0, 0);
        @(negedge clk);
        rst   = 1'b0;
        rises = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) rises++;
        end
        checkVal("midrst.no_out_valid", rises, 0, 0);
        applyStimulus(68629, lat);
        checkVal("midrst.recover_latency", lat, ITERS + 1, 0);
        checkOutput("midrst.recover", 32768, 56756, TOL);
        releaseOutput();

        for (int i = 0; i < 24; i++) begin
            ang = int'($urandom_range(0, 1234000)) - 617000;
            tag = $sformatf("rand[%0d] ang=%0d", i, ang);
            applyStimulus(ang, lat);
            checkVal({tag, ".latency"}, lat, ITERS + 1, 0);
            checkOutput(tag, modelCos(ang), modelSin(ang), TOL + 1);
            releaseOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
